// File: rtl/ls_pattern_gen_pkg.sv
// rtl/ls_pattern_gen_pkg.sv - shared state, pattern-select and PRBS7 constants
package ls_pattern_gen_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_MARK  = 3'd2;
  localparam logic [2:0] ST_PAT   = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  localparam logic [1:0] PAT_CHECKER = 2'b00;
  localparam logic [1:0] PAT_ONES    = 2'b01;
  localparam logic [1:0] PAT_ZEROS   = 2'b10;
  localparam logic [1:0] PAT_PRBS7   = 2'b11;

  // x^7 + x^6 + 1: feedback from the two most significant stages
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  function automatic logic prbs7_feedback(input logic [6:0] state);
    return ^(state & PRBS7_TAPS);
  endfunction

endpackage

// File: rtl/ls_pattern_gen_prbs7_gen.sv
// rtl/ls_pattern_gen_prbs7_gen.sv - PRBS7 source, output is the MSB before each shift
module prbs7_gen
  import ls_pattern_gen_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic load,
  output logic bit_out
);

  logic [6:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= PRBS7_SEED;
    end else if (load) begin
      lfsr <= PRBS7_SEED;
    end else if (enable) begin
      lfsr <= {lfsr[5:0], prbs7_feedback(lfsr)};
    end
  end

  assign bit_out = lfsr[6];

endmodule

// File: rtl/ls_pattern_gen.sv
// rtl/ls_pattern_gen.sv - preamble/marker/pattern/flush serial generator with delayed reference
module ls_pattern_gen
  import ls_pattern_gen_pkg::*;
#(
  parameter int PRE_LEN   = 8,
  parameter int FLUSH_LEN = 64,
  parameter int REF_DLY   = 64,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       pat_sel,
  input  logic [LEN_W-1:0] burst_len,
  output logic             din,
  output logic             data_ref,
  output logic             sync,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_cnt
);

  localparam int PRE_W = $clog2(PRE_LEN + 1);
  localparam int FL_W  = $clog2(FLUSH_LEN + 1);
  localparam int MX_W  = (PRE_W > FL_W) ? PRE_W : FL_W;
  localparam int CNT_W = (LEN_W > MX_W) ? LEN_W : MX_W;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel_q;
  logic [LEN_W-1:0] len_q;
  logic             done_pend;
  logic             prbs_bit;
  logic             pat_bit;
  logic             accept;
  logic             kill;
  logic             send_pat;
  logic [REF_DLY-1:0] dly;

  // Outputs trail the state by one register, so busy (not state) gates new starts.
  assign accept   = (state == ST_IDLE) && start && !busy;
  assign kill     = abort && (state != ST_IDLE);
  assign send_pat = (state == ST_PAT) && !kill;

  prbs7_gen u_prbs7 (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (send_pat),
    .load    (accept),
    .bit_out (prbs_bit)
  );

  always_comb begin
    pat_bit = 1'b0;
    case (sel_q)
      PAT_CHECKER: pat_bit = ~bit_cnt[0];
      PAT_ONES:    pat_bit = 1'b1;
      PAT_ZEROS:   pat_bit = 1'b0;
      default:     pat_bit = prbs_bit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel_q <= PAT_CHECKER;
      len_q <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_PRE;
            cnt   <= CNT_W'(PRE_LEN - 1);
            sel_q <= pat_sel;
            len_q <= burst_len;
          end
        end
        ST_PRE: begin
          if (cnt == '0) state <= ST_MARK;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_MARK: begin
          if (len_q == '0) begin
            state <= ST_FLUSH;
            cnt   <= CNT_W'(FLUSH_LEN - 1);
          end else begin
            state <= ST_PAT;
            cnt   <= CNT_W'(len_q) - CNT_W'(1);
          end
        end
        ST_PAT: begin
          if (cnt == '0) begin
            state <= ST_FLUSH;
            cnt   <= CNT_W'(FLUSH_LEN - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din       <= 1'b0;
      sync      <= 1'b0;
      busy      <= 1'b0;
      done_pend <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      din       <= !kill && ((state == ST_MARK) || ((state == ST_PAT) && pat_bit));
      sync      <= !kill && (state == ST_MARK);
      busy      <= !kill && (state != ST_IDLE);
      done_pend <= !kill && (state == ST_FLUSH) && (cnt == '0);
      done      <= done_pend;
      if (accept)
        bit_cnt <= '0;
      else if (send_pat && (bit_cnt != '1))
        bit_cnt <= bit_cnt + LEN_W'(1);
    end
  end

  // Free-running so bits already sent keep draining after an abort.
  generate
    if (REF_DLY == 1) begin : g_dly_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly <= '0;
        else        dly <= din;
      end
    end else begin : g_dly_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly <= '0;
        else        dly <= {dly[REF_DLY-2:0], din};
      end
    end
  endgenerate

  assign data_ref = dly[REF_DLY-1];

endmodule

// File: tb/tb_ls_pattern_gen.sv
// tb/tb_ls_pattern_gen.sv - self-checking bench for ls_pattern_gen
module tb_ls_pattern_gen;

  localparam int PRE_LEN   = 8;
  localparam int FLUSH_LEN = 64;
  localparam int REF_DLY   = 64;
  localparam int LEN_W     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       pat_sel = 2'b00;
  logic [LEN_W-1:0] burst_len = '0;
  logic             din, data_ref, sync, busy, done;
  logic [LEN_W-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  logic cap_din[$], cap_sync[$], cap_busy[$], cap_done[$];
  logic prbs_ref [127];

  always #5 clk = ~clk;

  ls_pattern_gen #(
    .PRE_LEN(PRE_LEN), .FLUSH_LEN(FLUSH_LEN), .REF_DLY(REF_DLY), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pat_sel(pat_sel), .burst_len(burst_len),
    .din(din), .data_ref(data_ref), .sync(sync), .busy(busy),
    .done(done), .bit_cnt(bit_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void init_prbs();
    for (int n = 0; n < 7; n++) prbs_ref[n] = 1'b1;
    for (int n = 7; n < 127; n++) prbs_ref[n] = prbs_ref[n-7] ^ prbs_ref[n-6];
  endfunction

  function automatic void model_run(input logic [1:0] sel, input int len);
    exp_q.delete();
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 0; i < len; i++) begin
      case (sel)
        2'b00:   exp_q.push_back((i % 2) == 0);
        2'b01:   exp_q.push_back(1'b1);
        2'b10:   exp_q.push_back(1'b0);
        default: exp_q.push_back(prbs_ref[i % 127]);
      endcase
    end
    for (int i = 0; i < FLUSH_LEN; i++) exp_q.push_back(1'b0);
  endfunction

  // Pulses start for one edge, then scrambles the select/length inputs mid-run.
  task automatic launch(input logic [1:0] sel, input int len);
    pat_sel   = sel;
    burst_len = LEN_W'(len);
    start     = 1'b1;
    step();
    start     = 1'b0;
    pat_sel   = 2'($urandom);
    burst_len = LEN_W'($urandom);
  endtask

  task automatic capture(input int n);
    cap_din.delete(); cap_sync.delete(); cap_busy.delete(); cap_done.delete();
    repeat (n) begin
      step();
      cap_din.push_back(din);
      cap_sync.push_back(sync);
      cap_busy.push_back(busy);
      cap_done.push_back(done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({din, sync, busy, done, data_ref} !== 5'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs din/sync/busy/done/ref=%b%b%b%b%b bit_cnt=%0d required all zero",
               din, sync, busy, done, data_ref, bit_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_checkerboard();
    int total = PRE_LEN + 1 + 6 + FLUSH_LEN;
    model_run(2'b00, 6);
    launch(2'b00, 6);
    capture(total + 2);
    for (int i = 0; i < total + 2; i++) begin
      logic ed;
      ed = (i < total) ? exp_q[i] : 1'b0;
      checks++;
      if ({cap_din[i], cap_sync[i], cap_busy[i], cap_done[i]} !== {ed, i == PRE_LEN, i < total, i == total}) begin
        errors++;
        $display("FAIL checker_run cycle %0d din/sync/busy/done=%b%b%b%b required %b%b%b%b", i,
                 cap_din[i], cap_sync[i], cap_busy[i], cap_done[i], ed, i == PRE_LEN, i < total, i == total);
      end
    end
    checks++;
    if (bit_cnt !== LEN_W'(6)) begin
      errors++;
      $display("FAIL checker_bit_cnt got %0d required 6", bit_cnt);
    end
  endtask

  task automatic test_prbs7();
    int total = PRE_LEN + 1 + 127 + FLUSH_LEN;
    int ones = 0;
    model_run(2'b11, 127);
    launch(2'b11, 127);
    capture(total + 2);
    for (int i = 0; i < total + 2; i++) begin
      logic ed;
      ed = (i < total) ? exp_q[i] : 1'b0;
      checks++;
      if ({cap_din[i], cap_sync[i], cap_busy[i], cap_done[i]} !== {ed, i == PRE_LEN, i < total, i == total}) begin
        errors++;
        $display("FAIL prbs7_run cycle %0d din/sync/busy/done=%b%b%b%b required %b%b%b%b", i,
                 cap_din[i], cap_sync[i], cap_busy[i], cap_done[i], ed, i == PRE_LEN, i < total, i == total);
      end
    end
    for (int i = PRE_LEN + 1; i < PRE_LEN + 1 + 127; i++) ones += int'(cap_din[i]);
    checks++;
    if (ones != 64) begin
      errors++;
      $display("FAIL prbs7_ones got %0d required 64", ones);
    end
    checks++;
    if (bit_cnt !== LEN_W'(127)) begin
      errors++;
      $display("FAIL prbs7_bit_cnt got %0d required 127", bit_cnt);
    end
  endtask

  task automatic test_zero_len();
    int total = PRE_LEN + 1 + FLUSH_LEN;
    logic [1:0] sel = 2'($urandom);
    model_run(sel, 0);
    launch(sel, 0);
    capture(total + 2);
    for (int i = 0; i < total + 2; i++) begin
      logic ed;
      ed = (i < total) ? exp_q[i] : 1'b0;
      checks++;
      if ({cap_din[i], cap_sync[i], cap_busy[i], cap_done[i]} !== {ed, i == PRE_LEN, i < total, i == total}) begin
        errors++;
        $display("FAIL zero_len_run cycle %0d din/sync/busy/done=%b%b%b%b required %b%b%b%b", i,
                 cap_din[i], cap_sync[i], cap_busy[i], cap_done[i], ed, i == PRE_LEN, i < total, i == total);
      end
    end
    checks++;
    if (bit_cnt !== '0) begin
      errors++;
      $display("FAIL zero_len_bit_cnt got %0d required 0", bit_cnt);
    end
  endtask

  task automatic test_random_runs();
    repeat (4) begin
      logic [1:0] sel = 2'($urandom);
      int len = $urandom_range(1, 40);
      int total = PRE_LEN + 1 + len + FLUSH_LEN;
      repeat ($urandom_range(0, 3)) step();
      model_run(sel, len);
      launch(sel, len);
      capture(total + 2);
      for (int i = 0; i < total + 2; i++) begin
        logic ed;
        ed = (i < total) ? exp_q[i] : 1'b0;
        checks++;
        if ({cap_din[i], cap_sync[i], cap_busy[i], cap_done[i]} !== {ed, i == PRE_LEN, i < total, i == total}) begin
          errors++;
          $display("FAIL random_run sel %0d len %0d cycle %0d din/sync/busy/done=%b%b%b%b required %b%b%b%b",
                   sel, len, i, cap_din[i], cap_sync[i], cap_busy[i], cap_done[i],
                   ed, i == PRE_LEN, i < total, i == total);
        end
      end
      checks++;
      if (bit_cnt !== LEN_W'(len)) begin
        errors++;
        $display("FAIL random_bit_cnt got %0d required %0d", bit_cnt, len);
      end
    end
  endtask

  task automatic test_abort();
    logic [1:0] sel = 2'($urandom);
    int abort_j = -1;
    model_run(sel, 20);
    launch(sel, 20);
    for (int j = 0; j < 40 && abort_j < 0; j++) begin
      step();
      checks++;
      if (din !== exp_q[j]) begin
        errors++;
        $display("FAIL abort_pre_din cycle %0d got %b required %b", j, din, exp_q[j]);
      end
      if (bit_cnt == LEN_W'(3)) abort_j = j;
    end
    checks++;
    if (abort_j != PRE_LEN + 3) begin
      errors++;
      $display("FAIL abort_third_bit cycle got %0d required %0d", abort_j, PRE_LEN + 3);
    end
    if (abort_j < 0) abort_j = PRE_LEN + 3;
    abort = 1'b1;
    for (int j = abort_j + 1; j < abort_j + REF_DLY + 8; j++) begin
      logic sr;
      step();
      abort = 1'b0;
      sr = (j - REF_DLY >= 0 && j - REF_DLY <= abort_j) ? exp_q[j - REF_DLY] : 1'b0;
      checks++;
      if ({din, busy, done, data_ref} !== {1'b0, 1'b0, 1'b0, sr} || bit_cnt !== LEN_W'(3)) begin
        errors++;
        $display("FAIL abort_after cycle %0d din/busy/done/ref=%b%b%b%b bit_cnt=%0d required 000%b bit_cnt=3",
                 j, din, busy, done, data_ref, bit_cnt, sr);
      end
    end
  endtask

  task automatic test_start_in_flush_and_reset();
    int total = PRE_LEN + 1 + 10 + FLUSH_LEN;
    model_run(2'b01, 10);
    launch(2'b01, 10);
    for (int i = 0; i < total + 4; i++) begin
      logic ed;
      start = (i == total - 20);
      step();
      start = 1'b0;
      ed = (i < total) ? exp_q[i] : 1'b0;
      checks++;
      if ({din, busy, done} !== {ed, i < total, i == total}) begin
        errors++;
        $display("FAIL flush_start cycle %0d din/busy/done=%b%b%b required %b%b%b",
                 i, din, busy, done, ed, i < total, i == total);
      end
    end
    launch(2'b00, 20);
    repeat (PRE_LEN + 1 + 5) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({din, sync, busy, done, data_ref} !== 5'b0 || bit_cnt !== '0) begin
      errors++;
      $display("FAIL midrun_reset din/sync/busy/done/ref=%b%b%b%b%b bit_cnt=%0d required all zero",
               din, sync, busy, done, data_ref, bit_cnt);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < REF_DLY + 4; i++) begin
      step();
      checks++;
      if ({data_ref, busy, din} !== 3'b0) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d ref/busy/din=%b%b%b required 000", i, data_ref, busy, din);
      end
    end
    model_run(2'b11, 15);
    launch(2'b11, 15);
    capture(PRE_LEN + 1 + 15 + FLUSH_LEN + 2);
    for (int i = 0; i < PRE_LEN + 1 + 15 + FLUSH_LEN + 2; i++) begin
      int total2 = PRE_LEN + 1 + 15 + FLUSH_LEN;
      logic ed;
      ed = (i < total2) ? exp_q[i] : 1'b0;
      checks++;
      if ({cap_din[i], cap_busy[i], cap_done[i]} !== {ed, i < total2, i == total2}) begin
        errors++;
        $display("FAIL after_reset_run cycle %0d din/busy/done=%b%b%b required %b%b%b",
                 i, cap_din[i], cap_busy[i], cap_done[i], ed, i < total2, i == total2);
      end
    end
    checks++;
    if (bit_cnt !== LEN_W'(15)) begin
      errors++;
      $display("FAIL after_reset_bit_cnt got %0d required 15", bit_cnt);
    end
  endtask

  task automatic test_ref_delay_chain();
    logic [REF_DLY-1:0] chain = '0;
    int len = $urandom_range(50, 100);
    int n = PRE_LEN + 1 + len + FLUSH_LEN + REF_DLY + 4;
    int flip_i = PRE_LEN + REF_DLY + $urandom_range(0, 20);
    int err_clean = 0;
    int err_flip = 0;
    repeat (REF_DLY + 6) step();
    launch(2'b11, len);
    chain = {chain[REF_DLY-2:0], din};
    for (int i = 0; i < n; i++) begin
      logic out;
      step();
      out = chain[REF_DLY-1];
      if (data_ref !== out) err_clean++;
      if (data_ref !== ((i == flip_i) ? ~out : out)) err_flip++;
      chain = {chain[REF_DLY-2:0], din};
    end
    checks++;
    if (err_clean != 0) begin
      errors++;
      $display("FAIL chain_clean errors got %0d required 0", err_clean);
    end
    checks++;
    if (err_flip != 1) begin
      errors++;
      $display("FAIL chain_flip errors got %0d required 1", err_flip);
    end
  endtask

  initial begin
    init_prbs();
    test_reset();
    test_checkerboard();
    test_prbs7();
    test_zero_len();
    test_random_runs();
    test_abort();
    test_start_in_flush_and_reset();
    test_ref_delay_chain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls_pattern_gen.md
# ls_pattern_gen

Serial stimulus generator driving the data input of a shift-register chain under test, and the source of the reference stream for the chain-output error checker. Per run it emits a zero preamble, a single-bit sync marker, a burst of a selected pattern, then a zero flush that drains the chain. It also emits a copy of the transmitted stream delayed by a programmable number of cycles, so the checker compares chain output against an aligned reference.

## Interface
Parameters:
- PRE_LEN, 8: zero bits sent before the marker (≥2)
- FLUSH_LEN, 64: zero bits sent after the burst (≥ chain length)
- REF_DLY, 64: delay from DIN to DATA_REF in cycles (1..256)
- LEN_W, 16: width of BURST_LEN and BIT_CNT

Ports (clock and reset first):
- CLK  in  1  sole clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  begin a run; sampled only in IDLE
- ABORT  in  1  synchronous abort of a run in progress
- PAT_SEL  in  2  00 checkerboard 1010…, 01 all ones, 10 all zeros, 11 PRBS7
- BURST_LEN  in  LEN_W  number of pattern bits, captured at START
- DIN  out  1  registered serial bit to the chain input
- DATA_REF  out  1  DIN delayed exactly REF_DLY cycles
- SYNC  out  1  high during the cycle DIN carries the marker
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse at normal completion
- BIT_CNT  out  LEN_W  pattern bits sent in current or last run

## Operation
- States: IDLE → PRE → MARK → PAT → FLUSH → IDLE. ABORT from any non-IDLE state → IDLE.
- IDLE: DIN=0. START=1 captures PAT_SEL and BURST_LEN, clears BIT_CNT, seeds the LFSR with 7'h7F, and goes to PRE.
- PRE: DIN=0 for PRE_LEN cycles.
- MARK: DIN=1 and SYNC=1 for one cycle. The marker is the 0→1 edge the checker detects.
- PAT: BURST_LEN cycles. BIT_CNT increments once per pattern bit and saturates at all-ones.
  - Checkerboard starts with 1.
  - PRBS7 uses x^7+x^6+1; output bit = lfsr[6], then shift.
- BURST_LEN=0: PAT is skipped and MARK goes directly to FLUSH.
- FLUSH: DIN=0 for FLUSH_LEN cycles, then DONE=1 for one cycle while returning to IDLE.
- START while BUSY is ignored. PAT_SEL and BURST_LEN changes mid-run have no effect.
- ABORT has priority over all state transitions. DIN=0 from the next cycle, no DONE, BIT_CNT holds its value.
- Simultaneous START and ABORT in IDLE: START wins, because ABORT is meaningful only when BUSY.
- Delay line: REF_DLY-bit shift register fed by DIN. It keeps shifting in IDLE and after ABORT, so in-flight bits drain out normally.

## Timing
- START sampled at edge k. The first PRE bit is on DIN after edge k+1, with BUSY=1 from the same edge.
- The marker appears on DIN after edge k+1+PRE_LEN.
- The first pattern bit appears one cycle after the marker.
- DONE is asserted in the cycle after the last flush bit; BUSY=0 in that same cycle.
- Total run length: PRE_LEN+1+BURST_LEN+FLUSH_LEN cycles of BUSY.
- DATA_REF(t) = DIN(t−REF_DLY) exactly, with no extra register stage.
- Reset (RST_N=0, asynchronous, at any time including mid-run): state IDLE; DIN, SYNC, BUSY, DONE, DATA_REF = 0; BIT_CNT=0; LFSR=7'h7F; delay line all zeros. The first START is accepted on the first edge after RST_N rises.
- Down-counters for PRE/PAT/FLUSH are sized to cover max(PRE_LEN, FLUSH_LEN, 2^LEN_W−1). There is no wrap within a run.

## Structure
- Shared package: state encoding (IDLE, PRE, MARK, PAT, FLUSH), PAT_SEL codes, PRBS7 seed and tap constants. The chain checker reads the same PAT_SEL codes.
- One sub-module: prbs7_gen (enable, load, bit out). The checker can reuse it for self-checking mode.
- The delay line and the FSM live in the top level.

## Test plan
- PAT_SEL=00, BURST_LEN=6, PRE_LEN=8, FLUSH_LEN=64 → DIN = 8×0, 1, 101010, 64×0. SYNC aligned with the marker. DONE once after 79 BUSY cycles. BIT_CNT=6.
- PAT_SEL=11, BURST_LEN=127 → 127-bit sequence matches the PRBS7 golden model from seed 7'h7F; the sequence has 64 ones.
- BURST_LEN=0 → marker is followed immediately by 64 zeros, and DONE is asserted. BIT_CNT=0.
- ABORT in cycle 3 of PAT with BURST_LEN=20 → next DIN=0, BUSY=0, no DONE, BIT_CNT=3. DATA_REF still reproduces the aborted stream REF_DLY cycles later.
- START pulsed during FLUSH, then RST_N dropped mid-PAT → the START is ignored. Reset immediately zeros all outputs and the delay line, and a new run starts cleanly afterward.
- REF_DLY=64 with a 64-stage chain model between DIN and the checker → DATA_REF equals the chain output every cycle, giving zero checker errors. A single bit flip in the model gives exactly one error.
